// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame_if
//  Description : Line input and frame-result outputs of uart_rx_frame.
//                The err_count signal exists only with UART_RX_ERR_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_count;

    // Receiver side
    modport master (
        input  rx,
        output data, valid, parity_err, frame_err, busy, err_count
    );
    // Line driver / result consumer side
    modport slave (
        output rx,
        input  data, valid, parity_err, frame_err, busy, err_count
    );
`else
    // Receiver side
    modport master (
        input  rx,
        output data, valid, parity_err, frame_err, busy
    );
    // Line driver / result consumer side
    modport slave (
        output rx,
        input  data, valid, parity_err, frame_err, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : Single-line UART frame receiver, one line sample per clk.
//                Configurable data width (5..16), parity (none/even/odd) and
//                1 or 2 stop bits. Emits a registered word with a one-cycle
//                valid strobe, or a parity / framing error strobe.
//                Optional: UART_RX_ERR_CNT_EN adds a saturating err_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int ERR_CNT_W = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_rx_frame_if.master bus
);

    localparam int                c_CW   = $clog2(DATA_BITS);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(DATA_BITS - 1);
    localparam logic              c_ODD  = (PARITY == 2);

    localparam logic [2:0] c_ST_BREAK  = 3'd0;
    localparam logic [2:0] c_ST_IDLE   = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [c_CW-1:0]      r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par;
    logic                 r_par_err;
    logic                 r_stop_cnt;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    logic                 w_start;
    logic                 w_good;
    logic                 w_perr;
    logic                 w_ferr;
    logic                 w_last_stop;
    logic                 w_exp_par;

    assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;
    assign w_exp_par   = r_par ^ c_ODD;
    // DONE doubles as IDLE so a start bit can follow the strobe directly
    assign w_start     = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && !bus.rx;

    // Next-state decode and end-of-frame outcome
    always_comb begin
        w_next = r_state;
        w_good = 1'b0;
        w_perr = 1'b0;
        w_ferr = 1'b0;
        case (r_state)
            c_ST_BREAK: begin
                if (bus.rx) w_next = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                if (!bus.rx) w_next = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (r_cnt == c_LAST) w_next = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                w_next = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (!bus.rx) begin
                    // Low stop bit: framing error, also covers a line break
                    w_next = c_ST_BREAK;
                    w_ferr = 1'b1;
                end else if (w_last_stop) begin
                    w_next = c_ST_DONE;
                    if (r_par_err) w_perr = 1'b1;
                    else           w_good = 1'b1;
                end
            end
            c_ST_DONE: begin
                w_next = bus.rx ? c_ST_IDLE : c_ST_DATA;
            end
            default: begin
                w_next = c_ST_BREAK;
            end
        endcase
    end

    // State register and frame datapath (bit counter, shift register, parity)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_BREAK;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_start) begin
                r_cnt     <= '0;
                r_par     <= 1'b0;
                r_par_err <= 1'b0;
            end

            if (r_state == c_ST_DATA) begin
                r_shift[r_cnt] <= bus.rx;
                r_par          <= r_par ^ bus.rx;
                if (r_cnt != c_LAST) r_cnt <= r_cnt + c_CW'(1);
            end

            if (r_state == c_ST_PARITY) r_par_err <= (bus.rx != w_exp_par);

            // Counts accepted stop bits; only meaningful with two stop bits
            r_stop_cnt <= (r_state == c_ST_STOP) && bus.rx;
        end
    end

    // Registered outputs: strobes, held data word and busy flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_good;
            r_perr  <= w_perr;
            r_ferr  <= w_ferr;
            r_busy  <= (w_next == c_ST_DATA) || (w_next == c_ST_PARITY) ||
                       (w_next == c_ST_STOP);
            if (w_good) r_data <= r_shift;
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.busy       = r_busy;

`ifdef UART_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating total of parity and framing errors, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_cnt <= '0;
        end else if ((w_perr || w_ferr) && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.err_count = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_frame
//  Description : Directed bench for uart_rx_frame. Three instances:
//                A = 8N1, B = 7E1, C = 8N2 with a 2-bit error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] rx_l = 3'b111;
    int         cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if #(.DATA_BITS(8), .ERR_CNT_W(8)) if_a ();
    uart_rx_frame_if #(.DATA_BITS(7), .ERR_CNT_W(8)) if_b ();
    uart_rx_frame_if #(.DATA_BITS(8), .ERR_CNT_W(2)) if_c ();

    assign if_a.rx = rx_l[0];
    assign if_b.rx = rx_l[1];
    assign if_c.rx = rx_l[2];

    uart_rx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .ERR_CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .bus(if_a));
    uart_rx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .ERR_CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .bus(if_b));
    uart_rx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .ERR_CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .bus(if_c));

    // Strobe monitor, sampled on the falling edge
    logic [2:0]  mv, mp, mf;
    logic [15:0] md [3];
    assign mv    = {if_c.valid, if_b.valid, if_a.valid};
    assign mp    = {if_c.parity_err, if_b.parity_err, if_a.parity_err};
    assign mf    = {if_c.frame_err, if_b.frame_err, if_a.frame_err};
    assign md[0] = {8'h00, if_a.data};
    assign md[1] = {9'h000, if_b.data};
    assign md[2] = {8'h00, if_c.data};

    int          nv[3]     = '{0, 0, 0};
    int          np[3]     = '{0, 0, 0};
    int          nf[3]     = '{0, 0, 0};
    int          pv_cyc[3] = '{0, 0, 0};
    int          lv_cyc[3] = '{0, 0, 0};
    int          lp_cyc[3] = '{0, 0, 0};
    int          lf_cyc[3] = '{0, 0, 0};
    logic [15:0] pv_dat[3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] lv_dat[3] = '{16'h0, 16'h0, 16'h0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mv[i]) begin
                nv[i]     <= nv[i] + 1;
                pv_cyc[i] <= lv_cyc[i];
                lv_cyc[i] <= cyc;
                pv_dat[i] <= lv_dat[i];
                lv_dat[i] <= md[i];
            end
            if (mp[i]) begin
                np[i]     <= np[i] + 1;
                lp_cyc[i] <= cyc;
            end
            if (mf[i]) begin
                nf[i]     <= nf[i] + 1;
                lf_cyc[i] <= cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n line bits, bit 0 first, one per cycle
    task automatic send(input int d, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_l[d] = bits[i];
            tick();
        end
    endtask

    task automatic hold(input int d, input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            rx_l[d] = val;
            tick();
        end
    endtask

    // Line image of a frame: start, data LSB first, optional parity, stop bits
    function automatic logic [31:0] mk_frame(input logic [15:0] d, input int nd,
                                             input int np_bits, input logic pb,
                                             input int ns, input logic [1:0] sv);
        logic [31:0] f;
        int k;
        f = '0;
        k = 1;
        for (int i = 0; i < nd; i++) begin
            f[k] = d[i];
            k++;
        end
        if (np_bits != 0) begin
            f[k] = pb;
            k++;
        end
        for (int i = 0; i < ns; i++) begin
            f[k] = sv[i];
            k++;
        end
        return f;
    endfunction

    int c0, bv, bp, bf;

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_data",  {24'h0, if_a.data}, 32'h0);
        check_eq("rst_valid", {31'h0, if_a.valid}, 32'h0);
        check_eq("rst_perr",  {31'h0, if_b.parity_err}, 32'h0);
        check_eq("rst_ferr",  {31'h0, if_c.frame_err}, 32'h0);
        check_eq("rst_busy",  {31'h0, if_a.busy}, 32'h0);
`ifdef UART_RX_ERR_CNT_EN
        check_eq("rst_errcnt", {30'h0, if_c.err_count}, 32'h0);
`endif
        reset = 1'b1;
        hold(0, 1'b1, 2);

        // ---------------- 8N1 0xA5, stream 1,1,0,1,0,1,0,0,1,0,1,1 ----------------
        c0 = cyc; bv = nv[0]; bp = np[0]; bf = nf[0];
        send(0, 32'h0000_0D2B, 12);
        hold(0, 1'b1, 2);
        check_eq("a5_valid_cnt", nv[0] - bv, 1);
        check_eq("a5_valid_cyc", lv_cyc[0] - c0, 12);
        check_eq("a5_data",      {24'h0, if_a.data}, 32'hA5);
        check_eq("a5_err_cnt",   (np[0] - bp) + (nf[0] - bf), 0);
        check_eq("a5_busy_idle", {31'h0, if_a.busy}, 32'h0);

        // ---------------- back-to-back 0x3C, 0xC3 ----------------
        c0 = cyc; bv = nv[0];
        send(0, mk_frame(16'h3C, 8, 0, 1'b0, 1, 2'b11), 10);
        send(0, mk_frame(16'hC3, 8, 0, 1'b0, 1, 2'b11), 10);
        hold(0, 1'b1, 2);
        check_eq("b2b_valid_cnt", nv[0] - bv, 2);
        check_eq("b2b_cyc1",      pv_cyc[0] - c0, 10);
        check_eq("b2b_cyc2",      lv_cyc[0] - c0, 20);
        check_eq("b2b_dat1",      {16'h0, pv_dat[0]}, 32'h3C);
        check_eq("b2b_dat2",      {16'h0, lv_dat[0]}, 32'hC3);

        // ---------------- 7E1 parity ----------------
        c0 = cyc; bv = nv[1];
        send(1, mk_frame(16'h12, 7, 1, 1'b0, 1, 2'b11), 10);
        hold(1, 1'b1, 2);
        check_eq("e_good12_valid", nv[1] - bv, 1);
        check_eq("e_good12_cyc",   lv_cyc[1] - c0, 10);
        check_eq("e_good12_data",  {25'h0, if_b.data}, 32'h12);

        c0 = cyc; bv = nv[1]; bp = np[1];
        send(1, mk_frame(16'h41, 7, 1, 1'b1, 1, 2'b11), 10);
        hold(1, 1'b1, 2);
        check_eq("e_bad41_perr",  np[1] - bp, 1);
        check_eq("e_bad41_cyc",   lp_cyc[1] - c0, 10);
        check_eq("e_bad41_valid", nv[1] - bv, 0);
        check_eq("e_bad41_data",  {25'h0, if_b.data}, 32'h12);

        bv = nv[1]; bp = np[1];
        send(1, mk_frame(16'h41, 7, 1, 1'b0, 1, 2'b11), 10);
        hold(1, 1'b1, 2);
        check_eq("e_good41_valid", nv[1] - bv, 1);
        check_eq("e_good41_perr",  np[1] - bp, 0);
        check_eq("e_good41_data",  {25'h0, if_b.data}, 32'h41);

        // ---------------- 8N2 framing error and break ----------------
        c0 = cyc; bv = nv[2]; bf = nf[2];
        send(2, mk_frame(16'h55, 8, 0, 1'b0, 2, 2'b01), 11);
        hold(2, 1'b0, 10);
        check_eq("n2_ferr_cnt",  nf[2] - bf, 1);
        check_eq("n2_ferr_cyc",  lf_cyc[2] - c0, 11);
        check_eq("n2_no_valid",  nv[2] - bv, 0);
        check_eq("n2_brk_busy",  {31'h0, if_c.busy}, 32'h0);
        check_eq("n2_data_kept", {24'h0, if_c.data}, 32'h0);
`ifdef UART_RX_ERR_CNT_EN
        check_eq("errcnt_1", {30'h0, if_c.err_count}, 32'd1);
`endif
        hold(2, 1'b1, 1);
        c0 = cyc; bv = nv[2];
        send(2, mk_frame(16'h55, 8, 0, 1'b0, 2, 2'b11), 11);
        hold(2, 1'b1, 2);
        check_eq("n2_good_valid", nv[2] - bv, 1);
        check_eq("n2_good_cyc",   lv_cyc[2] - c0, 11);
        check_eq("n2_good_data",  {24'h0, if_c.data}, 32'h55);
`ifdef UART_RX_ERR_CNT_EN
        check_eq("errcnt_hold", {30'h0, if_c.err_count}, 32'd1);
`endif

        // four more framing errors (first stop bit low)
        for (int j = 0; j < 4; j++) begin
            bf = nf[2];
            send(2, mk_frame(16'hF0, 8, 0, 1'b0, 2, 2'b10), 11);
            hold(2, 1'b1, 2);
            check_eq("n2_loop_ferr", nf[2] - bf, 1);
`ifdef UART_RX_ERR_CNT_EN
            check_eq("errcnt_seq", {30'h0, if_c.err_count}, (j == 0) ? 32'd2 : 32'd3);
`endif
        end
        check_eq("n2_data_after_errs", {24'h0, if_c.data}, 32'h55);

        // ---------------- reset mid-frame ----------------
        bv = nv[0]; bp = np[0]; bf = nf[0];
        send(0, mk_frame(16'h96, 8, 0, 1'b0, 1, 2'b11), 5);
        check_eq("rstmid_busy", {31'h0, if_a.busy}, 32'h1);
        rx_l[0] = 1'b0;
        reset   = 1'b0;
        tick();
        reset   = 1'b1;
        check_eq("rstmid_data",  {24'h0, if_a.data}, 32'h0);
        check_eq("rstmid_valid", {31'h0, if_a.valid}, 32'h0);
        check_eq("rstmid_busy0", {31'h0, if_a.busy}, 32'h0);
`ifdef UART_RX_ERR_CNT_EN
        check_eq("rstmid_errcnt", {30'h0, if_c.err_count}, 32'h0);
`endif
        hold(0, 1'b0, 15);
        check_eq("rstmid_no_valid", nv[0] - bv, 0);
        check_eq("rstmid_no_err",   (np[0] - bp) + (nf[0] - bf), 0);
        check_eq("rstmid_low_busy", {31'h0, if_a.busy}, 32'h0);
        hold(0, 1'b1, 1);
        c0 = cyc; bv = nv[0];
        send(0, mk_frame(16'h5A, 8, 0, 1'b0, 1, 2'b11), 10);
        hold(0, 1'b1, 2);
        check_eq("post_rst_valid", nv[0] - bv, 1);
        check_eq("post_rst_cyc",   lv_cyc[0] - c0, 10);
        check_eq("post_rst_data",  {24'h0, if_a.data}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised single-line UART frame receiver for the serial front end. The block samples `rx` once per `clk` cycle and recovers frames of configurable data width, parity mode and stop-bit count. Each frame yields either a registered data word with a one-cycle `valid` strobe or a parity/framing error strobe. It generalises the fixed 8N1 frame validator: it adds a data path, parity, two stop bits, error reporting and back-to-back frame reception.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..16, LSB first on the line.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `ERR_CNT_W`, 8: width of error counter (only with `UART_RX_ERR_CNT_EN`).

Ports:
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `rx`  in  1  serial line, one bit per cycle, idle high.
- `data`  out  DATA_BITS  last received word; held until the next good frame.
- `valid`  out  1  one-cycle strobe: `data` updated by a good frame.
- `parity_err`  out  1  one-cycle strobe: frame completed with bad parity.
- `frame_err`  out  1  one-cycle strobe: a stop bit sampled low.
- `busy`  out  1  high while in DATA, PARITY or STOP.
- `err_count`  out  ERR_CNT_W  saturating error total (macro only).

## Operation
- States: BREAK, IDLE, DATA, PARITY, STOP, DONE.
- BREAK: `rx`=1 -> IDLE; `rx`=0 -> stay.
- IDLE: `rx`=0 (start bit) -> DATA, bit counter = 0; `rx`=1 -> stay.
- DATA: `rx` written to shift register bit `cnt`; running parity XOR updated. At `cnt`=DATA_BITS-1, go to PARITY if PARITY≠0, else go to STOP. Otherwise increment `cnt`.
- PARITY: compare `rx` against the expected bit:
  - even: XOR of data bits;
  - odd: its inverse.
  - Latch a mismatch flag, then go to STOP, stop counter = 0.
- STOP: `rx`=0 -> assert `frame_err` next cycle and go to BREAK (covers line break). `rx`=1 on the last stop bit -> DONE. `rx`=1 otherwise -> next stop bit.
- DONE, entered after a completed frame:
  - Parity flag clear: `data` <= shift register, `valid`=1.
  - Parity flag set: `parity_err`=1, `data` unchanged.
  - In the same cycle DONE acts as IDLE: `rx`=0 -> DATA (back-to-back frame); `rx`=1 -> IDLE.
- A frame error discards the word. `data` is never written on an error.
- Illegal state encoding -> BREAK.
- `valid`, `parity_err` and `frame_err` are mutually exclusive and never high for two consecutive cycles from the same frame.

## Timing
- Reset values: state BREAK, `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `err_count`=0.
- All outputs are registered; there is no combinational path from `rx` to any output.
- Start bit sampled in cycle t:
  - data bits occupy t+1..t+DATA_BITS;
  - the parity bit (if any) follows;
  - stop bits follow the parity bit;
  - the `valid`/`parity_err` strobe appears in the cycle after the last stop-bit sample.
- Example, 8N1: start at t, strobe at t+10.
- `frame_err` appears the cycle after the failing stop-bit sample.
- Minimum frame period is 1+DATA_BITS+(PARITY≠0)+STOP_BITS cycles. The next start bit may be sampled in the strobe (DONE) cycle.
- Reset mid-frame: the partial frame is discarded, no strobe is raised, state returns to BREAK.
- After reset, a frame is only accepted once `rx` has been high for at least one cycle.

## Configuration
- `UART_RX_ERR_CNT_EN` defined: port `err_count` exists.
  - Increments by 1 on every `parity_err` or `frame_err` strobe.
  - Saturates at 2^ERR_CNT_W-1.
  - Cleared only by reset.
- `UART_RX_ERR_CNT_EN` undefined: no `err_count` port and no counter logic. All other behaviour is identical.

## Test plan
- 8N1 frame 0xA5, with `rx` stream 1,1,0,1,0,1,0,0,1,0,1,1 -> `valid`=1 for exactly one cycle 10 cycles after the start bit; `data`=0xA5; no error strobes.
- Back-to-back 8N1 frames 0x3C then 0xC3, the second start bit sampled in the first DONE cycle -> two `valid` strobes 10 cycles apart; `data`=0x3C then 0xC3.
- PARITY=1 (even), DATA_BITS=7, word 0x41 with parity bit 1 (wrong) -> `parity_err` pulse, `valid`=0, `data` keeps its previous value. Repeat with parity bit 0 -> `valid`, `data`=0x41.
- STOP_BITS=2, second stop bit 0 -> `frame_err` pulse. Further `rx`=0 keeps the block in BREAK with no strobes. `rx`=1 then a good frame 0x55 -> `valid`, `data`=0x55.
- Reset (`reset`=0 for one cycle) asserted at data bit 4 of a frame -> all outputs 0 next cycle and no strobe for that frame. With `rx` held low after reset, nothing is accepted until `rx` returns high.
- With `UART_RX_ERR_CNT_EN` and ERR_CNT_W=2: 5 framing errors -> `err_count` sequence 1,2,3,3,3.
